seq_mul_core: RTL and testbench
===============================

SEQ_MUL_CORE -- requirements
Module: seq_mul_core

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand width in bits; the result width is 2*WIDTH.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port multiplicand, input, WIDTH bits: unsigned operand A.
REQ-005 SHALL have port multiplier, input, WIDTH bits: unsigned operand B.
REQ-006 SHALL have port op_start, input, 1 bit: start request from the initiator (level-sampled).
REQ-007 SHALL have port op_clear, input, 1 bit: abort/clear request from the initiator (level-sampled).
REQ-008 SHALL have port op_done, output, 1 bit: product valid; registered.
REQ-009 SHALL have port result, output, 2*WIDTH bits: accumulator/product; registered.

Function
REQ-010 SHALL implement the FSM states IDLE, EXEC and DONE.
REQ-011 SHALL give op_clear priority over op_start in every state: when op_clear is sampled high, next state = IDLE, result = 0, op_done = 0, counter = 0.
REQ-012 SHALL, in IDLE with op_start=1 and op_clear=0 at edge t0, latch multiplicand and multiplier into internal registers, clear the accumulator and counter, and enter EXEC.
REQ-013 SHALL perform one radix-2 shift-add step per EXEC cycle: if the multiplier-register LSB=1, accumulator += multiplicand-register << counter; then multiplier-register >>= 1 and counter += 1.
REQ-014 SHALL transition EXEC -> DONE on the edge that completes the final step, and set op_done=1 on that same edge; without the macro this is edge t0+WIDTH (t0+64).
REQ-015 SHALL hold result and op_done=1 in DONE until op_clear is sampled high; op_start SHALL be ignored in DONE.
REQ-016 SHALL ignore op_start and input-operand changes during EXEC, because the operands are captured at t0.
REQ-017 SHALL drive result directly from the accumulator; its value is architecturally valid only while op_done=1.
REQ-018 SHALL compute the product modulo nothing: the full 2*WIDTH-bit unsigned product, with no overflow possible.
REQ-019 SHALL remain in IDLE, with result = 0 and op_done = 0, when op_start=0.

Reset
REQ-020 SHALL, when reset_n is sampled low, set state = IDLE, result = 0, op_done = 0, counter = 0 and operand registers = 0, regardless of state, including mid-EXEC.
REQ-021 SHALL, once reset_n is released, take the first op_start no earlier than the next rising edge.

Configuration
REQ-022 SHALL support the macro SEQ_MUL_EARLY_TERM_EN. When it is defined, EXEC ends (-> DONE, op_done=1) on the edge where the shifted multiplier-register becomes zero after the current step, with a minimum of 1 EXEC cycle; multiplier = 0 or 1 therefore completes at t0+1.
REQ-023 SHALL, when SEQ_MUL_EARLY_TERM_EN is not defined, always take exactly WIDTH EXEC cycles; the result SHALL be identical in both builds.

Structure
REQ-024 SHALL place the state encoding (IDLE=2'b00, EXEC=2'b01, DONE=2'b10), WIDTH default and counter width (clog2(WIDTH)+1) in the shared package seq_mul_pkg.
REQ-025 SHALL implement the 2*WIDTH-bit accumulator addition in one combinational sub-module, mul_add128 (inputs a, b; output sum).
REQ-026 SHALL keep all registers in seq_mul_core and use no latches; the combinational block SHALL assign defaults for every signal in every state.

Verification
REQ-027 SHALL cover: start with A=5, B=6 at t0 -> op_done=1 after t0+64, result=30; op_done stays high for 10 idle cycles.
REQ-028 SHALL cover: A=B=0xFFFF_FFFF_FFFF_FFFF -> result=0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
REQ-029 SHALL cover: op_clear pulse at EXEC cycle 20 -> next cycle IDLE, result=0, op_done=0; a new start with A=7, B=9 then yields 63.
REQ-030 SHALL cover: op_start and op_clear high together in IDLE -> remains IDLE, no capture, op_done=0.
REQ-031 SHALL cover: reset_n low at EXEC cycle 30 -> all outputs 0 on the next edge; a subsequent start with A=3, B=4 yields 12.
REQ-032 SHALL cover: with SEQ_MUL_EARLY_TERM_EN defined, A=3, B=1 -> op_done at t0+1, result=3; B=0x80 -> op_done at t0+8, result=0x180.

Source files
------------

// File: rtl/seq_mul_pkg.sv
// -----------------------------------------------------------------------------
// seq_mul_pkg
// Shared definitions for the sequential shift-add multiplier:
//   - FSM state encoding (IDLE / EXEC / DONE)
//   - default operand width and the derived step-counter width
// Used by: seq_mul_core
// -----------------------------------------------------------------------------
package seq_mul_pkg;

    localparam int WIDTH_DEF = 64;

    // The counter must be able to hold WIDTH itself (it increments once more
    // on the final step), hence the extra bit.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

    localparam int CNT_W_DEF = cnt_width(WIDTH_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/mul_add128.sv
// -----------------------------------------------------------------------------
// mul_add128
// Purely combinational accumulator adder for the shift-add multiplier.
// Ports:
//   a   - current accumulator value (W bits)
//   b   - partial product to add    (W bits)
//   sum - a + b, truncated to W bits; the multiplier's operand sizing
//         guarantees the true sum never exceeds W bits.
// -----------------------------------------------------------------------------
module mul_add128 #(
    parameter int W = 128
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/seq_mul_core.sv
// -----------------------------------------------------------------------------
// seq_mul_core
// Radix-2 sequential unsigned multiplier. Operands are captured on a start
// request, then one shift-add step is performed per EXEC cycle. The full
// 2*WIDTH-bit product is presented on result with op_done held high until an
// op_clear request.
//
// Ports:
//   clk          - clock, all state updates on the rising edge
//   reset_n      - synchronous active-low reset
//   multiplicand - operand A (WIDTH bits, unsigned)
//   multiplier   - operand B (WIDTH bits, unsigned)
//   op_start     - start request, sampled in IDLE only
//   op_clear     - abort/clear request, highest priority in every state
//   op_done      - registered product-valid flag
//   result       - registered accumulator (2*WIDTH bits)
//
// Build option:
//   SEQ_MUL_EARLY_TERM_EN - when defined, EXEC ends as soon as the remaining
//   multiplier bits are all zero (minimum one EXEC cycle). Without it, EXEC
//   always lasts exactly WIDTH cycles. The product is the same either way.
// -----------------------------------------------------------------------------
module seq_mul_core
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 op_start,
    input  logic                 op_clear,
    output logic                 op_done,
    output logic [2*WIDTH-1:0]   result
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_done;

    logic [2*WIDTH-1:0]   w_mcand_ext;
    logic [2*WIDTH-1:0]   w_addend;
    logic [2*WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]     w_mplier_shr;
    logic                 w_last;

    // Partial product for the current step: multiplicand weighted by the
    // position of the multiplier bit currently sitting in the LSB.
    assign w_mcand_ext  = {{WIDTH{1'b0}}, r_mcand};
    assign w_addend     = r_mplier[0] ? (w_mcand_ext << r_cnt) : '0;
    assign w_mplier_shr = r_mplier >> 1;

    mul_add128 #(
        .W   (2*WIDTH)
    ) u_add (
        .a   (r_acc),
        .b   (w_addend),
        .sum (w_sum)
    );

    // w_last marks the step whose completing edge moves EXEC -> DONE.
`ifdef SEQ_MUL_EARLY_TERM_EN
    // Once no set multiplier bits remain, further steps would only add zero.
    assign w_last = (w_mplier_shr == '0);
`else
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (op_start) w_state_nxt = EXEC;
            EXEC:    if (w_last)   w_state_nxt = DONE;
            DONE:    w_state_nxt = DONE;
            default: w_state_nxt = IDLE;
        endcase
        if (op_clear) begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
        end else if (op_clear) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (op_start) begin
                        r_mcand  <= multiplicand;
                        r_mplier <= multiplier;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_done   <= 1'b0;
                    end
                end
                EXEC: begin
                    r_acc    <= w_sum;
                    r_mplier <= w_mplier_shr;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    // DONE holds the product until cleared.
                end
            endcase
        end
    end

    assign op_done = r_done;
    assign result  = r_acc;

endmodule

// File: tb/tb_seq_mul_core.sv
module tb_seq_mul_core;

    localparam int WIDTH = 64;
`ifdef SEQ_MUL_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset_n;
    logic [WIDTH-1:0]   multiplicand;
    logic [WIDTH-1:0]   multiplier;
    logic               op_start;
    logic               op_clear;
    logic               op_done;
    logic [2*WIDTH-1:0] result;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_mul_core #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .op_start     (op_start),
        .op_clear     (op_clear),
        .op_done      (op_done),
        .result       (result)
    );

    // Reference: exact unsigned product in 128-bit arithmetic.
    function automatic logic [127:0] ref_prod(input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        p = {64'd0, a} * {64'd0, b};
        return p;
    endfunction

    // Reference latency (edges after the capture edge until op_done is seen).
    function automatic int ref_lat(input logic [63:0] b);
        int h;
        h = 0;
        for (int i = 0; i < 64; i++) begin
            if (b[i]) h = i + 1;
        end
        if (EARLY) return (h == 0) ? 1 : h;
        return WIDTH;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_op();
        op_clear = 1'b1;
        tick();
        op_clear = 1'b0;
    endtask

    task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                          input bit scramble, input string tag);
        int           cyc;
        int           lat;
        logic [127:0] exp;
        exp = ref_prod(a, b);
        lat = ref_lat(b);
        clear_op();
        multiplicand = a;
        multiplier   = b;
        op_start     = 1'b1;
        tick();
        op_start = 1'b0;
        cyc = 0;
        while (op_done !== 1'b1 && cyc < WIDTH + 4) begin
            if (scramble) begin
                multiplicand = rand64();
                multiplier   = rand64();
                op_start     = 1'($urandom_range(0, 1));
            end
            tick();
            cyc++;
        end
        op_start = 1'b0;
        chk({tag, " latency"}, 128'(cyc), 128'(lat));
        chk({tag, " result"}, result, exp);
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] b;

        reset_n      = 1'b0;
        op_start     = 1'b0;
        op_clear     = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        tick();
        tick();
        chk("reset op_done", 128'(op_done), 128'(0));
        chk("reset result", result, 128'(0));

        reset_n = 1'b1;
        repeat (3) tick();
        chk("idle op_done", 128'(op_done), 128'(0));
        chk("idle result", result, 128'(0));

        // 5 x 6, then DONE must hold for 10 cycles, ignoring op_start.
        run_op(64'd5, 64'd6, 1'b0, "a5b6");
        for (int i = 0; i < 10; i++) begin
            op_start     = (i == 3);
            multiplicand = rand64();
            multiplier   = rand64();
            tick();
            chk("done hold op_done", 128'(op_done), 128'(1));
            chk("done hold result", result, 128'd30);
        end
        op_start = 1'b0;
        clear_op();
        chk("clear op_done", 128'(op_done), 128'(0));
        chk("clear result", result, 128'(0));

        // Largest operands.
        run_op('1, '1, 1'b0, "max");
        chk("max literal", result, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);

        // Abort in the middle of EXEC.
        clear_op();
        multiplicand = rand64();
        multiplier   = rand64() | 64'h8000_0000_0000_0000;
        op_start     = 1'b1;
        tick();
        op_start = 1'b0;
        repeat (19) tick();
        op_clear = 1'b1;
        tick();
        op_clear = 1'b0;
        chk("abort op_done", 128'(op_done), 128'(0));
        chk("abort result", result, 128'(0));
        repeat (5) tick();
        chk("abort stays idle", result, 128'(0));
        run_op(64'd7, 64'd9, 1'b0, "a7b9");

        // Start and clear together: nothing may start.
        clear_op();
        multiplicand = rand64();
        multiplier   = rand64() | 64'h1;
        op_start     = 1'b1;
        op_clear     = 1'b1;
        tick();
        op_start = 1'b0;
        op_clear = 1'b0;
        chk("start+clear op_done", 128'(op_done), 128'(0));
        chk("start+clear result", result, 128'(0));
        repeat (WIDTH + 2) tick();
        chk("start+clear no run op_done", 128'(op_done), 128'(0));
        chk("start+clear no run result", result, 128'(0));

        // Reset in the middle of EXEC.
        multiplicand = rand64() | 64'h1;
        multiplier   = rand64() | 64'h8000_0000_0000_0001;
        op_start     = 1'b1;
        tick();
        op_start = 1'b0;
        repeat (29) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("midreset op_done", 128'(op_done), 128'(0));
        chk("midreset result", result, 128'(0));
        run_op(64'd3, 64'd4, 1'b0, "a3b4");

        // Operand and start changes during EXEC must be ignored.
        run_op(rand64(), rand64(), 1'b1, "scramble");

        // Short multipliers (early-termination boundaries).
        run_op(64'd3, 64'd1, 1'b0, "a3b1");
        chk("a3b1 literal", result, 128'd3);
        run_op(64'd3, 64'h80, 1'b0, "a3b80");
        chk("a3b80 literal", result, 128'h180);
        run_op(rand64(), 64'd0, 1'b0, "b0");

        // Random operands of varied multiplier length.
        for (int i = 0; i < 8; i++) begin
            a = rand64();
            b = rand64();
            if (i % 2 == 1) b = b >> $urandom_range(0, 63);
            run_op(a, b, 1'(i % 3 == 0), "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
